// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the SRAM slave.
// Also holds the size/alignment helpers used at address-phase decode.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Illegal size or an access not naturally aligned to its size.
  function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
    return (size > WORD) || ((size == HALF) && lsb[0]) || ((size == WORD) && (lsb != 2'b00));
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      BYTE:    be = 4'b0001 << lsb;
      HALF:    be = lsb[1] ? 4'b1100 : 4'b0011;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_bytes.sv
// Byte-lane storage: four lane arrays with per-lane write enables and a
// word-wide combinational read port. Every byte clears on reset.
module ahb_sram_bytes #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-3:0] raddr,
  output logic [31:0]       rdata
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg [WORDS];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < WORDS; i++) begin
            lane_reg[i] <= 8'h00;
          end
        end else if (we[gi]) begin
          lane_reg[waddr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_reg[raddr];
    end
  endgenerate

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: little-endian byte-addressed array with programmable
// wait states on OKAY data phases and a two-cycle ERROR response.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  slave_state_e      state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              write_reg, write_next;
  logic [2:0]        size_reg, size_next;

  logic        accept;
  logic        req_err;
  logic        data_done;
  logic        can_accept;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        unused_bits;

  // Bursts are decoded beat by beat, so burst type, protection and SEQ-vs-NONSEQ carry no meaning here.
  assign unused_bits = ^{HBURST, HPROT, HTRANS[0]};

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign req_err    = size_err(HSIZE, HADDR[1:0]);
  assign data_done  = (state_reg == ST_DATA) && (cnt_reg == 4'd0);
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2) || data_done;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    size_next  = size_reg;
    case (state_reg)
      ST_DATA: if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
      ST_ERR1: state_next = ST_ERR2;
      default: ;
    endcase
    if (can_accept) begin
      state_next = ST_IDLE;
      if (accept) begin
        addr_next  = HADDR;
        write_next = HWRITE;
        size_next  = HSIZE;
        if (req_err) begin
          state_next = ST_ERR1;
        end else begin
          state_next = ST_DATA;
          cnt_next   = WAIT_INIT;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      size_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      size_reg  <= size_next;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_reg)
      ST_DATA: HREADYOUT = (cnt_reg == 4'd0);
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // Errored accesses never reach DATA, so size_reg is always legal here.
  assign we     = (data_done && write_reg) ? lane_enable(size_reg, addr_reg[1:0]) : 4'b0000;
  assign HRDATA = (data_done && !write_reg) ? rdata : '0;

  ahb_sram_bytes #(
    .ADDR_W(ADDR_W)
  ) u_bytes (
    .clk  (HCLK),
    .rst_n(HRESET),
    .we   (we),
    .waddr(addr_reg[ADDR_W-1:2]),
    .wdata(HWDATA),
    .raddr(addr_reg[ADDR_W-1:2]),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench for ahb_lite_sram_slave: runs the same traffic against a
// zero-wait instance and a two-wait-state instance selected in turn.
module tb_ahb_lite_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  logic        sel;
  logic        sel0, sel1;
  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;

  always #5 HCLK = ~HCLK;

  assign sel0      = HSEL & ~sel;
  assign sel1      = HSEL & sel;
  assign HREADYOUT = sel ? ro1 : ro0;
  assign HRESP     = sel ? rs1 : rs0;
  assign HRDATA    = sel ? rd1 : rd0;
  assign HREADY    = HREADYOUT;

  ahb_lite_sram_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahb_lite_sram_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model [256];
  logic [31:0] pend_wdata;
  int          ws;
  int          vectors;
  int          miscompares;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [7:0] base;
    logic       hit;
    base = {a[7:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      hit = (sz == 3'd2) || (sz == 3'd1 && (i / 2) == int'(a[1])) || (sz == 3'd0 && i == int'(a[1:0]));
      if (hit) model[base + 8'(i)] = wd[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [7:0] base;
    base = {a[7:2], 2'b00};
    return {model[base + 8'd3], model[base + 8'd2], model[base + 8'd1], model[base]};
  endfunction

  task automatic do_reset();
    HRESET = 1'b0;
    HSEL   = 1'b0;
    HTRANS = 2'd0;
    HADDR  = 8'h00;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HBURST = 3'd0;
    HPROT  = 4'd0;
    HWDATA = 32'h0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b1;
    sb.delete();
    model_clear();
    pend_wdata = 32'h0;
    @(negedge HCLK);
    check_val("reset/hreadyout", 32'(HREADYOUT), 32'd1);
    check_val("reset/hresp", 32'(HRESP), 32'd0);
    check_val("reset/hrdata", HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
  endtask

  // Drives one address phase (with the previous beat's HWDATA) and retires
  // the previous beat from the scoreboard when its data phase completes.
  task automatic issue(input string name, input logic [1:0] tr, input logic [7:0] a,
                       input logic w, input logic [2:0] sz, input logic [31:0] wd,
                       input logic [2:0] burst);
    exp_t e;
    exp_t f;
    logic err;
    logic rdy_edge;
    logic done;
    int   waits;
    err     = tr[1] && ((sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00));
    e.name  = name;
    e.data  = 32'h0;
    e.resp  = err;
    e.waits = !tr[1] ? 0 : (err ? 1 : ws);
    if (tr[1] && !err) begin
      if (w) model_write(a, sz, wd);
      else   e.data = model_read(a);
    end
    sb.push_back(e);

    HSEL   = 1'b1;
    HTRANS = tr;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HBURST = burst;
    HWDATA = pend_wdata;
    waits  = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge HCLK);
      rdy_edge = HREADYOUT;
      if (sb.size() > 1) begin
        f = sb[0];
        if (!HREADYOUT) begin
          waits++;
          check_val({f.name, "/stall_resp"}, 32'(HRESP), 32'(f.resp));
        end else begin
          check_val({f.name, "/hrdata"}, HRDATA, f.data);
          check_val({f.name, "/hresp"}, 32'(HRESP), 32'(f.resp));
          check_val({f.name, "/waits"}, 32'(waits), 32'(f.waits));
          void'(sb.pop_front());
        end
      end
      @(posedge HCLK);
      #1;
      if (rdy_edge) done = 1'b1;
    end
    if (!done) check_val({name, "/timeout"}, 32'd0, 32'd1);
    pend_wdata = wd;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel         = 1'b0;
    ws          = 0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      ws  = (s == 1) ? 2 : 0;
      do_reset();

      issue("wr10", 2'd2, 8'h10, 1'b1, 3'd2, 32'hDEADBEEF, 3'd0);
      issue("rd10", 2'd2, 8'h10, 1'b0, 3'd2, 32'h0, 3'd0);

      issue("wb20", 2'd2, 8'h20, 1'b1, 3'd0, 32'h00000011, 3'd0);
      issue("wb21", 2'd2, 8'h21, 1'b1, 3'd0, 32'h00002200, 3'd0);
      issue("wb22", 2'd2, 8'h22, 1'b1, 3'd0, 32'h00330000, 3'd0);
      issue("wb23", 2'd2, 8'h23, 1'b1, 3'd0, 32'h44000000, 3'd0);
      issue("rd20a", 2'd2, 8'h20, 1'b0, 3'd2, 32'h0, 3'd0);
      issue("wh22", 2'd2, 8'h22, 1'b1, 3'd1, 32'hAAAA0000, 3'd0);
      issue("rd20b", 2'd2, 8'h20, 1'b0, 3'd2, 32'h0, 3'd0);

      issue("wmis05", 2'd2, 8'h05, 1'b1, 3'd2, 32'h12345678, 3'd0);
      issue("rd04", 2'd2, 8'h04, 1'b0, 3'd2, 32'h0, 3'd0);
      issue("rsz3", 2'd2, 8'h08, 1'b0, 3'd3, 32'h0, 3'd0);
      issue("idle_err2", 2'd0, 8'h08, 1'b0, 3'd2, 32'h0, 3'd0);
      issue("whmis21", 2'd2, 8'h21, 1'b1, 3'd1, 32'hBBBBBBBB, 3'd0);
      issue("rd20c", 2'd2, 8'h20, 1'b0, 3'd2, 32'h0, 3'd0);

      issue("w30", 2'd2, 8'h30, 1'b1, 3'd2, 32'hCAFEF00D, 3'd0);
      issue("r30", 2'd2, 8'h30, 1'b0, 3'd2, 32'h0, 3'd0);

      issue("b40", 2'd2, 8'h40, 1'b1, 3'd2, 32'h01010101, 3'd3);
      issue("b44", 2'd3, 8'h44, 1'b1, 3'd2, 32'h02020202, 3'd3);
      issue("busy", 2'd1, 8'h48, 1'b1, 3'd2, 32'hFFFFFFFF, 3'd3);
      issue("b48", 2'd3, 8'h48, 1'b1, 3'd2, 32'h03030303, 3'd3);
      issue("idle1", 2'd0, 8'h4C, 1'b1, 3'd2, 32'hFFFFFFFF, 3'd0);
      issue("b4c", 2'd2, 8'h4C, 1'b1, 3'd2, 32'h04040404, 3'd0);
      issue("rb40", 2'd2, 8'h40, 1'b0, 3'd2, 32'h0, 3'd3);
      issue("rb44", 2'd3, 8'h44, 1'b0, 3'd2, 32'h0, 3'd3);
      issue("rb48", 2'd3, 8'h48, 1'b0, 3'd2, 32'h0, 3'd3);
      issue("rh4e", 2'd3, 8'h4E, 1'b0, 3'd1, 32'h0, 3'd3);

      issue("wbff", 2'd2, 8'hFF, 1'b1, 3'd0, 32'h77000000, 3'd0);
      issue("rdfc", 2'd2, 8'hFC, 1'b0, 3'd2, 32'h0, 3'd0);
      issue("flush", 2'd0, 8'h00, 1'b0, 3'd0, 32'h0, 3'd0);

      if (s == 1) begin
        issue("w50", 2'd2, 8'h50, 1'b1, 3'd2, 32'h5A5A5A5A, 3'd0);
        HTRANS = 2'd0;
        HWDATA = pend_wdata;
        @(negedge HCLK);
        check_val("midrst/wait_rdy", 32'(HREADYOUT), 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(negedge HCLK);
        check_val("midrst/hreadyout", 32'(HREADYOUT), 32'd1);
        check_val("midrst/hresp", 32'(HRESP), 32'd0);
        sb.delete();
        model_clear();
        pend_wdata = 32'h0;
        @(posedge HCLK);
        #1;
        issue("rd50", 2'd2, 8'h50, 1'b0, 3'd2, 32'h0, 3'd0);
        issue("flush2", 2'd0, 8'h00, 1'b0, 3'd0, 32'h0, 3'd0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
